// File: rtl/fx_bus_pkg.sv
// fx_bus_pkg: shared definitions for the FX register bus read-return path.
//   fx_state_e : read FSM states (ST_IDLE, ST_WAIT)
//   ERR_*      : err_code values reported with each returned word
//   CNT_W      : width of the saturating collision counter
package fx_bus_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } fx_state_e;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_TMO  = 2'b01;
    localparam logic [1:0] ERR_COLL = 2'b10;

    localparam int CNT_W = 8;

endpackage

// File: rtl/fx_bus_reduce.sv
// fx_bus_reduce: combinational ack-masked OR-reduce of N_CH channel words.
//   ch_q      in  N_CH*DW  channel data, channel i at [i*DW +: DW]
//   ch_ack    in  N_CH     per-channel response valid
//   red_q     out DW       OR over channels of (data & ack)
//   any_ack   out 1        at least one ack bit set
//   multi_ack out 1        two or more ack bits set (collision)
module fx_bus_reduce #(
    parameter int N_CH = 8,
    parameter int DW   = 8
) (
    input  logic [N_CH*DW-1:0] ch_q,
    input  logic [N_CH-1:0]    ch_ack,
    output logic [DW-1:0]      red_q,
    output logic               any_ack,
    output logic               multi_ack
);

    always_comb begin
        red_q     = '0;
        any_ack   = 1'b0;
        multi_ack = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            red_q = red_q | (ch_q[i*DW +: DW] & {DW{ch_ack[i]}});
            // A second ack after any earlier one flags a collision.
            if (ch_ack[i]) begin
                multi_ack = multi_ack | any_ack;
                any_ack   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fx_bus_mux.sv
// fx_bus_mux: read-data return path for the FX register bus.
// Accepts a read strobe, waits for slave acks, returns one registered word.
//   clk_sys  in  1        system clock
//   rst      in  1        synchronous active-high reset
//   rd_req   in  1        read strobe, accepted only in IDLE
//   ch_q     in  N_CH*DW  channel data
//   ch_ack   in  N_CH     per-channel response valid
//   clr_cnt  in  1        clears coll_cnt (wins over increment)
//   fx_q     out DW       registered read data
//   fx_vld   out 1        one-cycle pulse, fx_q valid
//   fx_err   out 1        pulses with fx_vld on timeout/collision
//   err_code out 2        status of last read, held until next fx_vld
//   coll_cnt out 8        saturating collision count
//   busy     out 1        high while waiting for a response
module fx_bus_mux
    import fx_bus_pkg::*;
#(
    parameter int            N_CH    = 8,
    parameter int            DW      = 8,
    parameter int            TIMEOUT = 16,
    parameter logic [DW-1:0] DFLT    = '1
) (
    input  logic               clk_sys,
    input  logic               rst,
    input  logic               rd_req,
    input  logic [N_CH*DW-1:0] ch_q,
    input  logic [N_CH-1:0]    ch_ack,
    input  logic               clr_cnt,
    output logic [DW-1:0]      fx_q,
    output logic               fx_vld,
    output logic               fx_err,
    output logic [1:0]         err_code,
    output logic [CNT_W-1:0]   coll_cnt,
    output logic               busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    fx_state_e     state;
    logic [TW-1:0] timer;
    logic [DW-1:0] red_q;
    logic          any_ack;
    logic          multi_ack;

    fx_bus_reduce #(
        .N_CH (N_CH),
        .DW   (DW)
    ) u_reduce (
        .ch_q      (ch_q),
        .ch_ack    (ch_ack),
        .red_q     (red_q),
        .any_ack   (any_ack),
        .multi_ack (multi_ack)
    );

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state    <= ST_IDLE;
            timer    <= '0;
            fx_q     <= '0;
            fx_vld   <= 1'b0;
            fx_err   <= 1'b0;
            err_code <= ERR_OK;
            coll_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            fx_vld <= 1'b0;
            fx_err <= 1'b0;
            if (clr_cnt) begin
                coll_cnt <= '0;
            end
            unique case (state)
                ST_IDLE: begin
                    // Acks seen here are stray and deliberately dropped.
                    if (rd_req) begin
                        state <= ST_WAIT;
                        timer <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // Ack is tested first so an ack on the final cycle beats timeout.
                    if (any_ack) begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        fx_q   <= red_q;
                        fx_vld <= 1'b1;
                        if (multi_ack) begin
                            err_code <= ERR_COLL;
                            fx_err   <= 1'b1;
                            if (!clr_cnt && coll_cnt != '1) begin
                                coll_cnt <= coll_cnt + CNT_W'(1);
                            end
                        end else begin
                            err_code <= ERR_OK;
                        end
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        fx_q     <= DFLT;
                        fx_vld   <= 1'b1;
                        fx_err   <= 1'b1;
                        err_code <= ERR_TMO;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fx_bus_mux.sv
// tb_fx_bus_mux: randomized scoreboard bench for fx_bus_mux.
module tb_fx_bus_mux;

    localparam int N_CH = 8;
    localparam int DW   = 8;
    localparam int TMO  = 16;
    localparam logic [DW-1:0] DFLT_V = '1;

    logic               clk_sys = 1'b0;
    logic               rst     = 1'b1;
    logic               rd_req  = 1'b0;
    logic [N_CH*DW-1:0] ch_q    = '0;
    logic [N_CH-1:0]    ch_ack  = '0;
    logic               clr_cnt = 1'b0;
    logic [DW-1:0]      fx_q;
    logic               fx_vld;
    logic               fx_err;
    logic [1:0]         err_code;
    logic [7:0]         coll_cnt;
    logic               busy;

    fx_bus_mux #(
        .N_CH    (N_CH),
        .DW      (DW),
        .TIMEOUT (TMO),
        .DFLT    (DFLT_V)
    ) dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .rd_req   (rd_req),
        .ch_q     (ch_q),
        .ch_ack   (ch_ack),
        .clr_cnt  (clr_cnt),
        .fx_q     (fx_q),
        .fx_vld   (fx_vld),
        .fx_err   (fx_err),
        .err_code (err_code),
        .coll_cnt (coll_cnt),
        .busy     (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int edge_cnt = 0;
    always @(posedge clk_sys) edge_cnt++;

    typedef struct {
        int            at_edge;
        logic [DW-1:0] q;
        logic [1:0]    err;
        logic          ferr;
        int            cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_cnt    = 0;           // model collision count
    logic [DW-1:0] m_last_q = '0; // model of held fx_q

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per fx_vld pulse.
    always @(negedge clk_sys) begin
        if (!rst) begin
            if (!fx_vld) begin
                chk("err_without_vld", 32'(fx_err), 32'd0);
            end else if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_vld: got fx_vld=1 expected no response (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("vld_edge", 32'(edge_cnt), 32'(e.at_edge));
                chk("fx_q", 32'(fx_q), 32'(e.q));
                chk("err_code", 32'(err_code), 32'(e.err));
                chk("fx_err", 32'(fx_err), 32'(e.ferr));
                chk("coll_cnt", 32'(coll_cnt), 32'(e.cnt));
                chk("busy_at_vld", 32'(busy), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Issue one read; the response is presented in WAIT cycle d (d>=TMO means none).
    task automatic do_read(input int d, input logic [N_CH-1:0] ack,
                           input logic [N_CH*DW-1:0] data, input bit clr);
        int   e0;
        int   last;
        exp_t e;
        logic [DW-1:0] word;
        rd_req = 1'b1;
        ch_ack = '0;
        tick();
        e0     = edge_cnt;
        rd_req = 1'b0;
        chk("busy_wait", 32'(busy), 32'd1);
        last = (d < TMO) ? d : TMO - 1;
        if (d < TMO) begin
            word = '0;
            for (int i = 0; i < N_CH; i++)
                if (ack[i]) word = word | data[i*DW +: DW];
            e.q = word;
            if ($countones(ack) >= 2) begin
                e.err = 2'b10; e.ferr = 1'b1;
                m_cnt = clr ? 0 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            end else begin
                e.err = 2'b00; e.ferr = 1'b0;
                if (clr) m_cnt = 0;
            end
        end else begin
            e.q = DFLT_V; e.err = 2'b01; e.ferr = 1'b1;
            if (clr) m_cnt = 0;
        end
        e.at_edge = e0 + last + 1;
        e.cnt     = m_cnt;
        m_last_q  = e.q;
        sb.push_back(e);
        for (int j = 0; j <= last; j++) begin
            rd_req = 1'($urandom_range(0, 1)); // ignored while waiting
            if (j == d) begin
                ch_ack = ack; ch_q = data; clr_cnt = clr;
            end else begin
                ch_ack = '0; ch_q = {$urandom, $urandom};
                clr_cnt = (j == last) ? clr : 1'b0;
            end
            tick();
        end
        ch_ack = '0; clr_cnt = 1'b0; rd_req = 1'b0;
    endtask

    task automatic idle_stray(input int n);
        for (int i = 0; i < n; i++) begin
            ch_ack = N_CH'($urandom);
            ch_q   = {$urandom, $urandom};
            tick();
        end
        ch_ack = '0;
    endtask

    logic [N_CH*DW-1:0] dat;

    initial begin
        repeat (3) tick();
        chk("rst_fx_q", 32'(fx_q), 32'd0);
        chk("rst_vld", 32'(fx_vld), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_coll_cnt", 32'(coll_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Single responder, others driving 0xFF.
        dat = '1; dat[2*DW +: DW] = 8'hA5;
        do_read(2, 8'h04, dat, 1'b0);
        // Collision.
        dat = '1; dat[0 +: DW] = 8'h30; dat[3*DW +: DW] = 8'h05;
        do_read(1, 8'h09, dat, 1'b0);
        // Timeout, then ack on the very last wait cycle.
        do_read(TMO, 8'h00, '0, 1'b0);
        dat = {$urandom, $urandom};
        do_read(TMO - 1, 8'h40, dat, 1'b0);
        // Minimum round trip, back-to-back.
        do_read(0, 8'h01, {$urandom, $urandom}, 1'b0);
        do_read(0, 8'h80, {$urandom, $urandom}, 1'b0);

        // Stray acks in IDLE: no response, no count, data held.
        tick();
        idle_stray(5);
        tick();
        chk("stray_cnt", 32'(coll_cnt), 32'(m_cnt));
        chk("hold_fx_q", 32'(fx_q), 32'(m_last_q));

        // clr_cnt concurrent with a collision.
        do_read(0, 8'h03, {$urandom, $urandom}, 1'b1);
        // Saturation.
        for (int k = 0; k < 260; k++)
            do_read(0, 8'hC0, {$urandom, $urandom}, 1'b0);
        tick();
        chk("sat_cnt", 32'(coll_cnt), 32'd255);

        // Randomized traffic.
        for (int k = 0; k < 150; k++) begin
            int d;
            logic [N_CH-1:0] a;
            d = ($urandom_range(0, 7) == 0) ? TMO + 1 : int'($urandom_range(0, TMO - 1));
            a = N_CH'($urandom);
            if (a == '0) a = N_CH'(1) << $urandom_range(0, N_CH - 1);
            do_read(d, a, {$urandom, $urandom}, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 2) == 0) idle_stray(int'($urandom_range(1, 2)));
        end

        // Reset mid-WAIT, then a late ack: no response, outputs cleared.
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_cnt = 0;
        m_last_q = '0;
        ch_ack = 8'h01; ch_q = {$urandom, $urandom};
        tick();
        ch_ack = '0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_fx_q", 32'(fx_q), 32'd0);
        chk("mid_rst_err", 32'(err_code), 32'd0);
        chk("mid_rst_cnt", 32'(coll_cnt), 32'd0);
        tick();
        chk("mid_rst_vld", 32'(fx_vld), 32'd0);

        // Normal read after reset.
        do_read(3, 8'h10, {$urandom, $urandom}, 1'b0);

        for (int w = 0; w < 40 && sb.size() != 0; w++) tick();
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending responses expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fx_bus_mux.md
Name: fx_bus_mux

Overview:
- Parametrised read-data return path for the FX register bus.
- Collects per-channel read data and per-channel acknowledges from N_CH slave blocks (syn, ad1..adN, dsp, ep, commu, pack, ...).
- Returns one registered word to the bus master per read request.
- Masks data by ack; detects multi-driver collisions and missing responses (timeout); keeps a saturating collision counter for diagnostics.

Parameters:
- N_CH, 8, number of slave channels (1..32).
- DW, 8, data width per channel.
- TIMEOUT, 16, max WAIT cycles before a read is aborted (>=1).
- DFLT, {DW{1'b1}}, value returned on timeout.
- TW, $clog2(TIMEOUT+1), derived localparam, timer width (not overridable).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_req  in  1  master read strobe; accepted only in IDLE.
- ch_q  in  N_CH*DW  channel data; channel i at [i*DW +: DW].
- ch_ack  in  N_CH  per-channel response valid; bit i qualifies channel i data.
- clr_cnt  in  1  clears coll_cnt.
- fx_q  out  DW  registered read data.
- fx_vld  out  1  one-cycle pulse, fx_q valid.
- fx_err  out  1  pulses with fx_vld when err_code != 0.
- err_code  out  2  00 ok, 01 timeout, 10 collision; held until next fx_vld.
- coll_cnt  out  8  saturating collision count.
- busy  out  1  high in WAIT.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, timer=0, fx_q=0, fx_vld=0, fx_err=0, err_code=00, coll_cnt=0, busy=0.
  - Reset mid-WAIT aborts the read with no fx_vld.
- States: IDLE, WAIT.
- IDLE:
  - rd_req=1 -> WAIT, timer=0, busy=1 from the next cycle.
  - ch_ack is ignored in IDLE (stray acks dropped, not counted).
- WAIT, on each cycle:
  - any ch_ack bit set -> capture and return to IDLE.
  - otherwise timer++; timer==TIMEOUT-1 with no ack -> timeout and return to IDLE.
- Capture rules:
  - fx_q <= OR over i of (ch_q[i] & {DW{ch_ack[i]}}).
  - Non-acking channels never corrupt data, even if they drive non-zero.
- Collision (popcount(ch_ack) >= 2):
  - fx_q is still the masked OR.
  - err_code=10, fx_err=1, coll_cnt increments.
- Timeout: fx_q <= DFLT, err_code=01, fx_err=1.
- Ack on the final WAIT cycle (timer==TIMEOUT-1) wins over timeout.
- Latency:
  - rd_req at edge n puts the block in WAIT from cycle n+1.
  - ack first seen in cycle k (k>=n+1) -> fx_vld high during cycle k+1.
  - Minimum round trip is 2 cycles.
  - Timeout -> fx_vld high during cycle n+TIMEOUT+1.
- fx_vld and fx_err are single-cycle pulses.
- The IDLE transition coincides with the fx_vld cycle, so a new rd_req is accepted in that same cycle.
- rd_req while in WAIT is ignored (no queueing).
- coll_cnt:
  - saturates at 255.
  - clr_cnt=1 forces 0 and wins over a simultaneous increment.
- fx_q holds its last value between reads.

Decomposition:
- Package fx_bus_pkg:
  - state encoding (ST_IDLE, ST_WAIT).
  - error codes (ERR_OK=2'b00, ERR_TMO=2'b01, ERR_COLL=2'b10).
  - counter width constant CNT_W=8.
- Sub-module fx_bus_reduce (combinational, parametrised N_CH/DW):
  - masked OR-reduce of ch_q by ch_ack.
  - any_ack and multi_ack (>=2) flags.
  - Unit-testable in isolation.
- Top holds the FSM, timer, output registers and counter.

Test Plan:
- Single responder: N_CH=8, DW=8; rd_req at cycle 0; ch_ack=8'h04, ch2 data=8'hA5 at cycle 3, all other channels driving 8'hFF -> fx_vld at cycle 4, fx_q=8'hA5, err_code=00, fx_err=0.
- Collision: ch_ack=8'h09, ch0=8'h30, ch3=8'h05 -> fx_q=8'h35, err_code=10, fx_err=1, coll_cnt 0->1.
- Timeout: TIMEOUT=16, no ack after rd_req at cycle 0 -> fx_vld at cycle 17, fx_q=8'hFF, err_code=01.
- Ack on the last WAIT cycle (cycle 16) -> ack data returned, no timeout.
- Boundaries:
  - 256 collisions -> coll_cnt=255 (saturated).
  - clr_cnt concurrent with a collision -> coll_cnt=0.
  - stray ack in IDLE -> no fx_vld, no count.
- Reset mid-WAIT: rst=1 at cycle 2 after rd_req, then ack at cycle 3 -> no fx_vld, busy=0, all outputs 0.
- Back-to-back: rd_req re-asserted in the fx_vld cycle -> accepted; second read completes normally.
